// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, controller state and instruction class types
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_NULL = 4'b1010;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK} state_t;
  typedef enum logic [2:0] {R, IALU, LOAD, STORE, ILLEGAL} class_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] f3_to_aluop(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational opcode/funct3/funct7 to {aluop, class} decode
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] aluop,
  output class_t     iclass
);

  logic r_legal;
  logic i_legal;

  assign r_legal = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  // Only the shift-immediates carry funct7 bits; other I-ALU ops use them as immediate
  assign i_legal = !((funct3 == 3'b001) && (funct7 != F7_BASE)) &&
                   !((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));

  always_comb begin
    aluop  = ALU_NULL;
    iclass = ILLEGAL;
    case (opcode)
      OP_R: begin
        if (r_legal) begin
          iclass = R;
          aluop  = f3_to_aluop(funct3, funct7[5]);
        end
      end
      OP_IALU: begin
        if (i_legal) begin
          iclass = IALU;
          aluop  = f3_to_aluop(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      OP_LOAD: begin
        iclass = LOAD;
        aluop  = ALU_ADD;
      end
      OP_STORE: begin
        iclass = STORE;
        aluop  = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32I datapath
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_addr,
  output logic       ir_en,
  output logic       pc_en,
  output logic       alu_en,
  output logic [3:0] aluop,
  output logic       sel_b,
  output logic       rf_en,
  output logic       wb_sel,
  output logic       illegal
);

  state_t     state_q, state_d;
  class_t     class_q;
  class_t     dec_class;
  logic [3:0] aluop_q;
  logic [3:0] dec_aluop;

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluop  (dec_aluop),
    .iclass (dec_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      class_q <= ILLEGAL;
      aluop_q <= ALU_NULL;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        class_q <= dec_class;
        aluop_q <= dec_aluop;
      end
    end
  end

  // Outputs are forced idle while rst is high so an abandoned access leaves no side effects
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_addr = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    alu_en       = 1'b0;
    aluop        = ALU_NULL;
    sel_b        = 1'b0;
    rf_en        = 1'b0;
    wb_sel       = 1'b0;
    illegal      = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ir_en   = mem_ready;
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          if (dec_class == ILLEGAL) begin
            illegal = 1'b1;
            pc_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = EXECUTE;
          end
        end
        EXECUTE: begin
          alu_en  = 1'b1;
          aluop   = aluop_q;
          sel_b   = (class_q != R);
          state_d = ((class_q == R) || (class_q == IALU)) ? WRITEBACK : MEM;
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_sel_addr = 1'b1;
          mem_we       = (class_q == STORE);
          if (mem_ready) begin
            pc_en   = (class_q == STORE);
            state_d = (class_q == STORE) ? FETCH : WRITEBACK;
          end
        end
        WRITEBACK: begin
          rf_en   = 1'b1;
          wb_sel  = (class_q == LOAD);
          pc_en   = 1'b1;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I integer datapath: steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states over one shared memory port. It drives the enables and selects of the existing register file, ALU operand mux and ALU (aluop, rf_en, sel_b), plus the PC, IR and memory handshake. It sits beside the datapath and replaces the single-cycle combinational decode at the top level.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- mem_ready  in  1  memory completes the requested access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- mem_sel_addr  out  1  address mux: 0 = PC, 1 = ALU result register
- ir_en  out  1  load IR from memory read data
- pc_en  out  1  PC <= PC + 4
- alu_en  out  1  load ALU result register
- aluop  out  4  ALU operation; NULL when not in EXECUTE
- sel_b  out  1  ALU B operand: 0 = rs2, 1 = immediate
- rf_en  out  1  register file write enable
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory data
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- Instruction classes, latched in DECODE into a class register: R (0110011), IALU (0010011), LOAD (0000011), STORE (0100011). Any other opcode is ILLEGAL.
- Encodings that are ILLEGAL:
  - R-type funct7 other than 0000000, or other than 0100000 when funct3 is 000 or 101.
  - IALU funct3 001 with funct7 not 0000000.
  - IALU funct3 101 with funct7 not 0000000 or 0100000.
- aluop decode:
  - R-type: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - IALU: same mapping by funct3. SRAI (funct7 0100000) maps to SRA.
  - LOAD and STORE: ADD.
- The funct3/funct7 decode result is registered with the class in DECODE. EXECUTE drives aluop from that register.
- FETCH: mem_req=1, mem_sel_addr=0. Hold until mem_ready. In the mem_ready cycle assert ir_en, then go to DECODE.
- DECODE: one cycle.
  - Legal instruction: go to EXECUTE.
  - ILLEGAL: illegal=1 and pc_en=1, then go to FETCH. No register write.
- EXECUTE: one cycle. aluop valid and alu_en=1. sel_b=1 for IALU, LOAD and STORE; 0 for R.
  - R or IALU: go to WRITEBACK.
  - LOAD or STORE: go to MEM.
- MEM: mem_req=1, mem_sel_addr=1, mem_we=1 only for STORE. Hold until mem_ready.
  - LOAD: go to WRITEBACK.
  - STORE: pc_en=1 in the mem_ready cycle, then go to FETCH.
- WRITEBACK: rf_en=1, wb_sel=1 for LOAD, pc_en=1, then go to FETCH.
- mem_ready is ignored whenever mem_req=0.
- Every output not stated for a state is 0 in that state; aluop is NULL (1010).

## Timing
- Reset:
  - While rst=1, all 1-bit outputs are 0, aluop=NULL, state=FETCH, class register = ILLEGAL.
  - The first cycle after rst deasserts is FETCH with mem_req=1.
  - rst asserted mid-instruction abandons it: no rf_en, pc_en or mem_we in the reset cycle. An outstanding memory access is dropped.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - R/IALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - ILLEGAL: 2 cycles.
- Each wait cycle with mem_ready=0 adds one cycle and holds all outputs steady.
- mem_req stays asserted from the first request cycle through the mem_ready cycle. It drops for at least one cycle between the fetch and the data access.
- pc_en, ir_en, rf_en and illegal each assert for exactly one cycle per instruction at most.
- Outputs are Moore (state-only), except ir_en and the STORE pc_en, which are also qualified by mem_ready.

## Structure
- Shared package riscv_pkg holds:
  - ALU op constants: ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001, NULL=1010.
  - Opcode constants.
  - Enum state_t {FETCH, DECODE, EXECUTE, MEM, WRITEBACK}.
  - Enum class_t {R, IALU, LOAD, STORE, ILLEGAL}.
- One sub-module, alu_decoder: combinational mapping of opcode/funct3/funct7 to {aluop, class}. The FSM registers its output in DECODE.

## Test plan
- ADD (funct7 0000000, funct3 000), mem_ready tied 1 → states F,D,E,W. aluop=0000 in E; rf_en=1, pc_en=1 in cycle 4 only.
- SRAI (0010011, funct3 101, funct7 0100000) → aluop=0111, sel_b=1 in E.
- LOAD with mem_ready low 2 cycles in MEM → mem_req high 3 cycles with mem_sel_addr=1, mem_we=0. wb_sel=1 and rf_en in WRITEBACK. Total 7 cycles.
- STORE → mem_we=1 in MEM; pc_en in the mem_ready cycle; rf_en never asserts.
- Opcode 1111111, and R-type funct7 0000001 → illegal=1 and pc_en=1 in DECODE; next cycle is FETCH; no rf_en.
- rst pulsed during MEM of a STORE → mem_req and mem_we are 0 in the reset cycle; FETCH restarts the next cycle; no pc_en.
